clk_freq_meter: RTL
===================

CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the edge counter and the result.
REQ-002 The block SHALL have parameter WIN_W, default 16, meaning the width of the gate-window length in core_clk cycles.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: core_clk and resetn.
REQ-004 Port core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port resetn  input  1  synchronous active-low reset.
REQ-006 Port meas_in  input  1  clock under measurement; asynchronous to core_clk.
REQ-007 Port start  input  1  measurement request; sampled only in IDLE.
REQ-008 Port window  input  WIN_W  gate length in core_clk cycles; captured at start acceptance.
REQ-009 Port busy  output  1  high while in ARM or MEASURE.
REQ-010 Port done  output  1  one-cycle pulse; result valid.
REQ-011 Port count  output  CNT_W  rising edges of meas_in counted in the last window; held until the next accepted start.
REQ-012 Port overflow  output  1  sticky; set when the counter saturated during the last window.

Function
REQ-013 meas_in SHALL pass through a 2-flop synchronizer, then a third flop; edge strobe = sync2 & ~sync3.
REQ-014 Valid measurement range SHALL be meas_in high and low phases each at least 2 core_clk periods; behaviour outside this range is unspecified.
REQ-015 The FSM SHALL have states IDLE, ARM, MEASURE, DONE.
REQ-016 IDLE with start=1 at edge N -> ARM at N+1: window is latched into the remaining counter, count cleared to 0, overflow cleared.
REQ-017 ARM -> MEASURE when latched window != 0; ARM -> DONE when latched window == 0, leaving count=0.
REQ-018 MEASURE SHALL last exactly window cycles; remaining decrements each cycle; remaining==1 -> DONE next.
REQ-019 An edge strobe asserted in any MEASURE cycle, including the last, SHALL increment count; strobes in IDLE, ARM and DONE are ignored.
REQ-020 count SHALL saturate at 2^CNT_W-1; a strobe arriving at saturation sets overflow, and count does not wrap.
REQ-021 DONE SHALL last one cycle with done=1, busy=0 and count/overflow final, then -> IDLE.
REQ-022 start in ARM, MEASURE or DONE SHALL be ignored; window changes after acceptance SHALL have no effect.
REQ-023 start held high continuously SHALL re-arm on each IDLE cycle: back-to-back measurements every window+3 cycles.
REQ-024 Latency: done asserts at edge N+2+window for start accepted at edge N (window=0: N+2).

Reset
REQ-025 When resetn=0 at a rising edge: state=IDLE, busy=0, done=0, count=0, overflow=0, remaining=0, synchronizer flops=0.
REQ-026 Reset asserted mid-ARM or mid-MEASURE SHALL abort the measurement with no done pulse; the next start after reset release runs normally.
REQ-027 The first edge strobe after reset SHALL NOT be generated from the synchronizer reset value unless meas_in actually rises.

Verification
REQ-028 meas_in stuck 0, window=100, start pulse -> busy 101 cycles, done at N+102, count=0, overflow=0.
REQ-029 meas_in period 8 core cycles (4 high/4 low), window=80 -> count=10, overflow=0; repeat with window=81..87 -> count 10 or 11 only, matching the strobe count in the window.
REQ-030 CNT_W=4 instance, meas_in period 4, window=100 -> count=15, overflow=1; a following run with window=8 -> count=2, overflow=0.
REQ-031 window=0 -> done at N+2, count=0; start pulsed during MEASURE of a window=50 run -> ignored, exactly one done pulse.
REQ-032 resetn low for 1 cycle at MEASURE cycle 20 of a window=80 run -> no done pulse, count=0, busy=0; next start gives count=10 at period 8.
REQ-033 start held high, window=16, meas_in period 8 -> done every 19 cycles, each count=2.

Source files
------------

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of an asynchronous clock over a gate window of core_clk cycles
module clk_freq_meter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             core_clk,
  input  logic             resetn,
  input  logic             meas_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] sync;
  logic [WIN_W-1:0] remaining;
  logic strobe;
  assign strobe = sync[1] & ~sync[2];
  assign busy = (state == ARM) || (state == MEASURE);
  assign done = state == DONE;
  // two-flop synchronizer plus a delay flop for rising-edge detection
  always_ff @(posedge core_clk)
    sync <= !resetn ? 3'b000 : {sync[1:0], meas_in};
  // state register
  always_ff @(posedge core_clk)
    state <= !resetn ? IDLE : state_nx;
  // next-state: a zero window skips MEASURE, the last window cycle goes to DONE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE    ? (start ? ARM : IDLE) :
               state == ARM     ? (remaining != '0 ? MEASURE : DONE) :
               state == MEASURE ? (remaining == WIN_W'(1) ? DONE : MEASURE) :
                                  IDLE;
  end
  // window countdown and saturating edge counter; results held until the next accepted start
  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      remaining <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else if (state == IDLE && start) begin
      remaining <= window;
      count     <= '0;
      overflow  <= 1'b0;
    end else if (state == MEASURE) begin
      remaining <= remaining - WIN_W'(1);
      if (strobe) begin
        if (&count) overflow <= 1'b1;
        else count <= count + CNT_W'(1);
      end
    end
  end
endmodule
